// File: rtl/ahb_ap_mem_responder.sv
// Wait-stated word memory behind a held ren/wen request; request_stall low marks the one-cycle RESP.
// Define AHB_AP_MEM_RESP_ERR_EN to fault out-of-range addresses instead of wrapping them modulo DEPTH.
module ahb_ap_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        AFT_CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  strobe,
    output logic [31:0] rdata,
    output logic        request_stall,
    output logic        error,
    output logic [1:0]  o_fsm_state
);

    // Handshake: ren/wen are held until the cycle in which request_stall is low (RESP).
    // That cycle completes the access; dropping both requests earlier, during WAIT, abandons it.
    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_op_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_strobe;
    logic [31:0] r_mem [DEPTH];

    logic        w_req;
    logic        w_resp;
    logic [31:0] w_offset;
    logic [AW-1:0] w_index;
    logic [31:0] w_word;
    logic        w_err;
    logic [1:0]  w_next_state;
    logic [3:0]  w_next_cnt;
    logic        w_unused;

    assign w_req    = ren | wen;
    assign w_offset = r_addr - BASE_ADDR;
    assign w_index  = w_offset[AW+1:2];
    assign w_word   = r_mem[w_index];

`ifdef AHB_AP_MEM_RESP_ERR_EN
    // DEPTH is a power of two, so any set bit above the index field means index >= DEPTH.
    assign w_err    = (r_addr < BASE_ADDR) || (w_offset[31:AW+2] != '0);
    assign w_unused = ^w_offset[1:0];
`else
    assign w_err    = 1'b0;
    assign w_unused = ^{w_offset[31:AW+2], w_offset[1:0]};
`endif

    // The IDLE accept cycle counts as the first stall cycle, so WAIT spans WAIT_CYCLES cycles.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_cnt   = WAIT_INIT;
                    w_next_state = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_next_state = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge AFT_CLK) begin
        if (!nRST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_op_wr  <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_strobe <= 4'h0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (r_state == ST_IDLE && w_req) begin
                r_op_wr  <= wen;
                r_addr   <= addr;
                r_wdata  <= wdata;
                r_strobe <= strobe;
            end
            if (r_state == ST_RESP && r_op_wr && !w_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_strobe[b]) begin
                        r_mem[w_index][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Outputs are gated by nRST so they read zero for the whole reset window.
    assign w_resp        = nRST && (r_state == ST_RESP);
    assign request_stall = nRST && (((r_state == ST_IDLE) && w_req) || (r_state == ST_WAIT));
    assign rdata         = w_resp ? (w_err ? 32'hBAD1_BAD1 : w_word) : 32'h0;
    assign error         = w_resp && w_err;
    assign o_fsm_state   = r_state;

endmodule

// File: tb/tb_ahb_ap_mem_responder.sv
// Directed bench: one DUT with WAIT_CYCLES=2 for the main checks, one with WAIT_CYCLES=0 for throughput.
module tb_ahb_ap_mem_responder;

    logic        clk;
    logic        nrst;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata;
    logic        stall, err;
    logic [1:0]  state;

    logic        ren_z, wen_z;
    logic [31:0] addr_z, wdata_z;
    logic [3:0]  strobe_z;
    logic [31:0] rdata_z;
    logic        stall_z, err_z;
    logic [1:0]  state_z;

    int n_cmp  = 0;
    int n_fail = 0;

    ahb_ap_mem_responder #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_CYCLES(2)) u_dut (
        .AFT_CLK(clk), .nRST(nrst), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .strobe(strobe), .rdata(rdata), .request_stall(stall), .error(err), .o_fsm_state(state)
    );

    ahb_ap_mem_responder #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_CYCLES(0)) u_dut_z (
        .AFT_CLK(clk), .nRST(nrst), .ren(ren_z), .wen(wen_z), .addr(addr_z), .wdata(wdata_z),
        .strobe(strobe_z), .rdata(rdata_z), .request_stall(stall_z), .error(err_z), .o_fsm_state(state_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds the request until the stall drops; returns RESP rdata/error and the stalled-cycle count.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic scramble,
                          output logic [31:0] rd, output logic e, output int n);
        @(posedge clk); #1;
        ren = r; wen = w; addr = a; wdata = d; strobe = s;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 20) begin
            chk("rdata_zero_while_stalled", rdata, 32'h0);
            n++;
            @(posedge clk); #1;
            if (scramble) begin
                addr = a + 32'h4; wdata = ~d; strobe = 4'hF;
            end
            #1;
        end
        rd = rdata;
        e  = err;
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0; strobe = 4'h0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          n;

    initial begin
        nrst = 1'b0; ren = 1'b1; wen = 1'b0; addr = 32'h8; wdata = 32'h0; strobe = 4'h0;
        ren_z = 1'b1; wen_z = 1'b0; addr_z = 32'h0; wdata_z = 32'h0; strobe_z = 4'h0;

        @(posedge clk); @(posedge clk); #2;
        chk("reset_stall", stall, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_error", err, 32'h0);
        chk("reset_state", state, 32'h0);
        chk("reset_stall_z", stall_z, 32'h0);
        chk("reset_rdata_z", rdata_z, 32'h0);
        @(posedge clk); #1;
        nrst = 1'b1; ren = 1'b0; ren_z = 1'b0; addr = 32'h0;

        access(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0, rd, e, n);
        chk("wr8_stall_cycles", n, 32'd3);
        chk("wr8_error", e, 32'h0);
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("rd8_stall_cycles", n, 32'd3);
        chk("rd8_rdata", rd, 32'hDEADBEEF);
        chk("rd8_error", e, 32'h0);

        access(1'b0, 1'b1, 32'h0, 32'h11223344, 4'hF, 1'b0, rd, e, n);
        access(1'b0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 1'b0, rd, e, n);
        access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("partial_strobe_rdata", rd, 32'h11BB33DD);

        access(1'b1, 1'b1, 32'h4, 32'h5, 4'hF, 1'b0, rd, e, n);
        chk("both_req_stall_cycles", n, 32'd3);
        access(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, rd, e, n);
        chk("both_req_is_write", rd, 32'h5);

        access(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 1'b0, rd, e, n);
        chk("strobe0_stall_cycles", n, 32'd3);
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, rd, e, n);
        chk("strobe0_unchanged", rd, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'hB, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("misaligned_rdata", rd, 32'hDEADBEEF);
        chk("misaligned_error", e, 32'h0);

        access(1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b1, rd, e, n);
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("latched_wdata", rd, 32'h12345678);
        access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("latched_addr_other_word", rd, 32'h0);

        access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rd, e, n);
`ifdef AHB_AP_MEM_RESP_ERR_EN
        chk("oor_rdata", rd, 32'hBAD1BAD1);
        chk("oor_error", e, 32'h1);
`else
        chk("wrap_rdata", rd, 32'h11BB33DD);
        chk("wrap_error", e, 32'h0);
`endif

        // Write abandoned in its second WAIT cycle.
        @(posedge clk); #1;
        wen = 1'b1; addr = 32'h4; wdata = 32'h99; strobe = 4'hF;
        #1;
        chk("abort_idle_stall", stall, 32'h1);
        @(posedge clk); #2;
        chk("abort_wait1_state", state, 32'd1);
        chk("abort_wait1_stall", stall, 32'h1);
        @(posedge clk); #1;
        wen = 1'b0;
        #1;
        chk("abort_wait2_stall", stall, 32'h1);
        @(posedge clk); #2;
        chk("abort_back_idle", state, 32'd0);
        chk("abort_no_resp_stall", stall, 32'h0);
        chk("abort_no_resp_rdata", rdata, 32'h0);
        access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("abort_word1_unchanged", rd, 32'h5);

        // Held read: one access every four cycles.
        @(posedge clk); #1;
        ren = 1'b1; addr = 32'h8;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_stall", stall, (i % 4 == 3) ? 32'h0 : 32'h1);
            if (i % 4 == 3) chk("b2b_rdata", rdata, 32'hDEADBEEF);
            @(posedge clk); #2;
        end
        ren = 1'b0;

        @(posedge clk); #1;
        wen_z = 1'b1; addr_z = 32'h0; wdata_z = 32'hCAFEF00D; strobe_z = 4'hF;
        #1;
        chk("w0_idle_stall", stall_z, 32'h1);
        @(posedge clk); #2;
        chk("w0_resp_stall", stall_z, 32'h0);
        @(posedge clk); #1;
        wen_z = 1'b0; ren_z = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("w0_stall_pattern", stall_z, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("w0_rdata_pattern", rdata_z, (i % 2 == 0) ? 32'h0 : 32'hCAFEF00D);
            @(posedge clk); #2;
        end
        ren_z = 1'b0;

        // Reset in the middle of a write.
        @(posedge clk); #1;
        wen = 1'b1; addr = 32'h8; wdata = 32'h777; strobe = 4'hF;
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("midrst_stall", stall, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        wen = 1'b0;
        #1;
        chk("midrst_state", state, 32'd0);
        chk("midrst_error", err, 32'h0);
        @(posedge clk); #1;
        nrst = 1'b1;
        access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("midrst_word2_zero", rd, 32'h0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("midrst_word0_zero", rd, 32'h0);
        access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, rd, e, n);
        chk("midrst_word1_zero", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_ap_mem_responder.md
AHB_AP_MEM_RESPONDER -- requirements
Module: ahb_ap_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 16: number of 32-bit words, power of two, range 2..256.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: extra stall cycles per access, range 0..15.
REQ-004 SHALL have port AFT_CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port nRST, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port ren, input, 1 bit: read request, held by the initiator until completion.
REQ-007 SHALL have port wen, input, 1 bit: write request, held by the initiator until completion.
REQ-008 SHALL have port addr, input, 32 bits: byte address of the access.
REQ-009 SHALL have port wdata, input, 32 bits: write data.
REQ-010 SHALL have port strobe, input, 4 bits: byte-lane enables; strobe[i] enables wdata[8i+7:8i].
REQ-011 SHALL have port rdata, output, 32 bits: read data.
REQ-012 SHALL have port request_stall, output, 1 bit: high while the access is not yet complete.
REQ-013 SHALL have port error, output, 1 bit: access fault, valid in the completion cycle only.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 SHALL accept a request in IDLE when ren|wen=1: latch op, addr, wdata and strobe, load counter with WAIT_CYCLES, go to WAIT.
REQ-016 SHALL give wen priority when ren and wen are both high; the access is a write.
REQ-017 SHALL drive request_stall=1 combinationally in IDLE when ren|wen=1, and in WAIT throughout.
REQ-018 SHALL decrement the counter each WAIT cycle and go to RESP in the cycle after it reads 0.
REQ-019 SHALL drive request_stall=0 in RESP; RESP lasts exactly one cycle, then the FSM returns to IDLE.
REQ-020 Read latency: request_stall high for WAIT_CYCLES+1 cycles, low in the RESP cycle; rdata is valid only in RESP.
REQ-021 SHALL hold rdata=32'h0 and error=0 in all states other than RESP.
REQ-022 SHALL compute word index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored with no fault.
REQ-023 SHALL commit a write at the rising edge ending the RESP cycle, updating only the lanes whose strobe bit is set.
REQ-024 strobe=4'b0000 write SHALL complete normally with memory unchanged.
REQ-025 A read SHALL return the full 32-bit word regardless of strobe.
REQ-026 If ren and wen both drop while in WAIT, the FSM SHALL abort to IDLE next cycle, with no write and no RESP.
REQ-027 SHALL sample a request still held in the IDLE cycle after RESP as a new access; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-028 SHALL use the latched addr, wdata and strobe for the whole access; input changes during WAIT are ignored.

Reset
REQ-029 While nRST=0 at a rising edge: state=IDLE, counter=0, latches=0, all memory words=32'h0.
REQ-030 During reset all outputs SHALL be 0: rdata=0, request_stall=0, error=0.
REQ-031 Reset asserted mid-access SHALL drop the access with no write commit.

Configuration
REQ-032 Macro AHB_AP_MEM_RESP_ERR_EN SHALL control address-range checking.
REQ-033 When defined: an index >= DEPTH, or addr < BASE_ADDR, SHALL give error=1 in RESP, rdata=32'hBAD1_BAD1, and a suppressed write.
REQ-034 When undefined: the index SHALL wrap modulo DEPTH, and error SHALL be tied 0.

Verification
REQ-035 WAIT_CYCLES=2, write addr=0x8 wdata=0xDEADBEEF strobe=4'hF, then read addr=0x8 -> stall high 3 cycles per access, rdata=0xDEADBEEF in RESP.
REQ-036 Word 0=0x11223344, write addr=0x0 wdata=0xAABBCCDD strobe=4'b0101, then read -> 0x11BB33DD.
REQ-037 ren=wen=1, addr=0x4, wdata=0x5 -> treated as a write; subsequent read of 0x4 returns 0x5.
REQ-038 Write to 0x4 with wen dropped in the 2nd WAIT cycle -> FSM returns to IDLE, no RESP, word 1 unchanged; nRST low mid-WAIT -> all outputs 0 next cycle, memory all zero.
REQ-039 With AHB_AP_MEM_RESP_ERR_EN defined, DEPTH=16, read addr=0x40 -> error=1, rdata=0xBAD1BAD1; without the macro, same read -> rdata equals word 0, error=0.
REQ-040 WAIT_CYCLES=0, read held continuously -> stall pattern 1,0,1,0... with rdata valid every second cycle.
